// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program loader.
package td4_pkg;

    localparam int unsigned TD4_AW    = 4;
    localparam int unsigned TD4_DW    = 8;
    localparam int unsigned TD4_DEPTH = 16;

    localparam logic [TD4_DW-1:0] CKSUM_GOOD = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } td4_state_e;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Pin-side load bus plus core-side fetch/hold signals of the TD4 program loader.
interface td4_prog_loader_if
    import td4_pkg::*;
#(
    parameter int unsigned AW = TD4_AW,
    parameter int unsigned DW = TD4_DW
);
    logic          ld_start;
    logic          ld_strobe;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          cpu_hold;
    logic          load_busy;
    logic [AW-1:0] load_addr;
    logic          load_err;

    modport master (
        output ld_start, ld_strobe, ld_data, pc,
        input  instr, cpu_hold, load_busy, load_addr, load_err
    );

    modport slave (
        input  ld_start, ld_strobe, ld_data, pc,
        output instr, cpu_hold, load_busy, load_addr, load_err
    );

endinterface

// File: rtl/td4_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a rising-edge pulse detector.
module td4_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin in at bit 0; the oldest sample sits at the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, async_i});
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program memory front end: pin-strobed 16-byte loader, combinational fetch, core hold.
// Optional PROG_CHECKSUM_EN appends a mod-256 checksum byte and an ERR state.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int unsigned DEPTH       = TD4_DEPTH,
    parameter int unsigned AW          = TD4_AW,
    parameter int unsigned DW          = TD4_DW,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    td4_prog_loader_if.slave bus
);

`ifdef PROG_CHECKSUM_EN
    localparam int unsigned CW = AW + 1;
`else
    localparam int unsigned CW = AW;
`endif

    td4_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          start_c, strobe_c, we_c;
    logic          cpu_hold_q, load_busy_q;
`ifdef PROG_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic          load_err_q;
`endif

    td4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .clk, .rst_n, .async_i(bus.ld_start), .rise_c(start_c)
    );

    td4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
        .clk, .rst_n, .async_i(bus.ld_strobe), .rise_c(strobe_c)
    );

    // Start wins over a coincident strobe; strobes outside LOAD are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_c    = 1'b0;
`ifdef PROG_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (start_c) begin
            state_d = LOAD;
            cnt_d   = '0;
`ifdef PROG_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (strobe_c) begin
`ifdef PROG_CHECKSUM_EN
                        if (cnt_q == CW'(DEPTH)) begin
                            cnt_d   = '0;
                            state_d = (DW'(sum_q + bus.ld_data) == CKSUM_GOOD) ? RUN : ERR;
                        end else begin
                            we_c  = 1'b1;
                            sum_d = DW'(sum_q + bus.ld_data);
                            cnt_d = cnt_q + CW'(1);
                        end
`else
                        we_c  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(DEPTH - 1)) begin
                            state_d = RUN;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cpu_hold_q  <= 1'b1;
            load_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_hold_q  <= (state_d != RUN);
            load_busy_q <= (state_d == LOAD);
        end
    end

`ifdef PROG_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            load_err_q <= (state_d == ERR);
        end
    end

    assign bus.load_err = load_err_q;
`else
    assign bus.load_err = 1'b0;
`endif

    // Flop-based program store; a same-cycle fetch of the written word sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (we_c) begin
            mem_q[cnt_q[AW-1:0]] <= bus.ld_data;
        end
    end

    assign bus.instr     = mem_q[bus.pc];
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_busy = load_busy_q;
    assign bus.load_addr = cnt_q[AW-1:0];

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Program-memory front end for the TD4 4-bit CPU core.
- Receives a 16-byte program from the chip pins through a strobed byte interface and stores it in a 16x8 flop-based program memory.
- Serves combinational instruction fetches addressed by the core's 4-bit PC.
- Holds the core in stall while a load is in progress and releases it when the load completes.

Parameters:
- DEPTH, 16, program words; must equal 2**AW.
- AW, 4, address width; matches the TD4 PC width.
- DW, 8, instruction width (4-bit opcode + 4-bit immediate).
- SYNC_STAGES, 2, synchronizer flops on the asynchronous pin inputs ld_strobe and ld_start.

Ports:
- clk  in  1  system clock, the same clock as the CPU core.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  pin-level request to begin a load; asynchronous, synchronized internally.
- ld_strobe  in  1  pin-level byte strobe; asynchronous, synchronized internally.
- ld_data  in  DW  load byte from the pins; must be quasi-static around ld_strobe.
- pc  in  AW  fetch address from the CPU core.
- instr  out  DW  instruction at pc; combinational read.
- cpu_hold  out  1  1 = core stalled or held in reset.
- load_busy  out  1  1 = state is LOAD.
- load_addr  out  AW  next write address.
- load_err  out  1  checksum error flag; tied 0 when PROG_CHECKSUM_EN is undefined.

Behaviour:
- Reset (async assert, sync deassert by the flops):
  - state=IDLE.
  - All memory words = 8'h00.
  - load_addr=0, cpu_hold=1, load_busy=0, load_err=0.
  - Synchronizer chains cleared to 0.
- Each async input passes through SYNC_STAGES flops. A rising edge is detected as sync_out & ~sync_prev, giving a one-cycle pulse.
- Pin-to-event latency is SYNC_STAGES+1 clk cycles.
- ld_data is sampled in the cycle the strobe pulse fires. External drivers hold ld_data stable from strobe rise to strobe fall, with the strobe high for at least SYNC_STAGES+2 cycles.
- States:
  - IDLE: cpu_hold=1. On a start pulse go to LOAD and set load_addr=0.
  - LOAD: cpu_hold=1, load_busy=1.
    - On a strobe pulse: mem[load_addr] <= ld_data and load_addr increments.
    - The write at load_addr==DEPTH-1 wraps load_addr to 0 and moves to RUN next cycle.
  - RUN: cpu_hold=0 beginning the cycle after the final write. On a start pulse go to LOAD with load_addr=0; cpu_hold rises in that same transition cycle.
- Boundaries:
  - A strobe pulse in IDLE or RUN is ignored; no write occurs.
  - A start pulse during LOAD restarts at address 0 and keeps previously written words; the new load overwrites them.
  - A start and strobe pulse in the same LOAD cycle: start wins and the byte is discarded.
  - An old strobe level present on entry to LOAD does not write; only a fresh rising edge writes.
  - Reset mid-load clears memory and returns to IDLE.
- Reads: instr = mem[pc] at all times, including during LOAD. The core is stalled then, so its value is don't-care. A write and a read at the same address in one cycle returns the old data.

Optional Feature:
- PROG_CHECKSUM_EN defined:
  - LOAD expects DEPTH+1 bytes. The final byte is a checksum, and the running 8-bit sum (mod 256) of all DEPTH+1 bytes must equal 8'h00.
  - On match: go to RUN.
  - On mismatch: go to state ERR, with cpu_hold=1 and load_err=1 held until the next start pulse (which clears load_err) or reset.
  - A 5-bit byte counter is used internally; load_addr still shows counter[AW-1:0].
- PROG_CHECKSUM_EN undefined: no ERR state, no sum register, load_err tied 0, exactly DEPTH bytes per load.

Decomposition:
- Package td4_pkg: state enum (IDLE, LOAD, RUN, ERR), TD4_AW=4, TD4_DW=8, TD4_DEPTH=16, CKSUM_GOOD=8'h00.
- One sub-module, td4_sync_edge: parameterized SYNC_STAGES synchronizer plus rising-edge detector. It is instantiated twice, for ld_start and ld_strobe.

Test Plan:
- Reset checks: after reset, cpu_hold=1, load_busy=0, and instr=8'h00 for all pc 0..15. Then pulse ld_strobe with ld_data=8'hAA while in IDLE -> mem[0] remains 00.
- Full load: start, then bytes 8'h01..8'h10 -> cpu_hold falls exactly 1 cycle after the 16th write, and instr at pc=k equals k+1.
- Restart: start, 5 bytes (8'hF0..8'hF4), start again, 16 bytes of 8'h33 -> load_addr returns to 0 and all 16 words read 8'h33.
- Start and strobe pulses landing in the same cycle during LOAD -> no write, load_addr=0, load_busy=1.
- Reload from RUN: start pulse -> cpu_hold=1 within SYNC_STAGES+1 cycles of the pin edge, and old contents stay readable until overwritten.
- With PROG_CHECKSUM_EN: 16 bytes of 8'h01 then 8'hF0 -> RUN, load_err=0. Same 16 bytes then 8'hF1 -> load_err=1 and cpu_hold=1, both cleared by the next start.
